// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage, the register file read/writeback ports
// and the ID/EX register; the ID/EX register itself uses the slave modport.
interface id_ex_stage_if #(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int CW = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rd;
  logic [AW-1:0] id_writereg;
  logic          id_regwrite;
  logic          id_memread;
  logic [3:0]    id_aluop;
  logic [DW-1:0] id_imm;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          regwriteW;
  logic [AW-1:0] writeregW;
  logic [DW-1:0] resultW;
  logic          ex_branch_taken;
  logic          mem_busy;
  logic          stall_f;
  logic          flush_d;
  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_memread;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rd;
  logic [AW-1:0] ex_writereg;
  logic [3:0]    ex_aluop;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic [CW-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rd, id_writereg, id_regwrite, id_memread,
           id_aluop, id_imm, rd1, rd2, regwriteW, writeregW, resultW,
           ex_branch_taken, mem_busy,
    input  stall_f, flush_d, ex_valid, ex_regwrite, ex_memread, ex_rs, ex_rd,
           ex_writereg, ex_aluop, ex_a, ex_b, ex_imm, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rd, id_writereg, id_regwrite, id_memread,
           id_aluop, id_imm, rd1, rd2, regwriteW, writeregW, resultW,
           ex_branch_taken, mem_busy,
    output stall_f, flush_d, ex_valid, ex_regwrite, ex_memread, ex_rs, ex_rd,
           ex_writereg, ex_aluop, ex_a, ex_b, ex_imm, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use stall, branch flush,
// memory-busy freeze and a saturating stall counter. Option: R0_ZERO_EN (r0 hardwired 0).
module id_ex_stage #(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic          ex_valid_reg, ex_valid_next;
  logic          ex_regwrite_reg, ex_regwrite_next;
  logic          ex_memread_reg, ex_memread_next;
  logic [AW-1:0] ex_rs_reg, ex_rs_next;
  logic [AW-1:0] ex_rd_reg, ex_rd_next;
  logic [AW-1:0] ex_writereg_reg, ex_writereg_next;
  logic [3:0]    ex_aluop_reg, ex_aluop_next;
  logic [DW-1:0] ex_a_reg, ex_a_next;
  logic [DW-1:0] ex_b_reg, ex_b_next;
  logic [DW-1:0] ex_imm_reg, ex_imm_next;
  logic [CW-1:0] stall_count_reg, stall_count_next;

  logic [1:0][AW-1:0] raddr;
  logic [1:0][DW-1:0] rdata;
  logic [1:0][DW-1:0] opnd;
  logic [1:0]         hit;
  logic               load_use;
  logic               count_inc;
  logic               capture;
  logic               bubble;
  logic               stall_f;
  logic               flush_d;

  assign raddr[0] = bus.id_rs;
  assign raddr[1] = bus.id_rd;
  assign rdata[0] = bus.rd1;
  assign rdata[1] = bus.rd2;

  // Operand 0 pairs rs/rd1, operand 1 pairs rd/rd2; both share bypass and hazard compare.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      logic fwd;
`ifdef R0_ZERO_EN
      assign fwd      = bus.regwriteW && (bus.writeregW != '0) && (bus.writeregW == raddr[gi]);
      assign opnd[gi] = (raddr[gi] == '0) ? '0 : (fwd ? bus.resultW : rdata[gi]);
      assign hit[gi]  = (ex_writereg_reg != '0) && (ex_writereg_reg == raddr[gi]);
`else
      assign fwd      = bus.regwriteW && (bus.writeregW == raddr[gi]);
      assign opnd[gi] = fwd ? bus.resultW : rdata[gi];
      assign hit[gi]  = (ex_writereg_reg == raddr[gi]);
`endif
    end
  endgenerate

  // A STALL cycle always has a bubble in EX, so the hazard cannot legitimately re-fire there.
  assign load_use = ex_valid_reg && ex_memread_reg && ex_regwrite_reg && bus.id_valid &&
                    (|hit) && (state_reg != STALL);

  always_comb begin
    state_next = state_reg;
    stall_f    = 1'b0;
    flush_d    = 1'b0;
    count_inc  = 1'b0;
    capture    = 1'b0;
    bubble     = 1'b0;
    if (!reset) begin
      if (bus.mem_busy) begin
        stall_f   = 1'b1;
        count_inc = 1'b1;
      end else if (bus.ex_branch_taken) begin
        bubble     = 1'b1;
        flush_d    = 1'b1;
        state_next = FLUSH;
      end else if (load_use) begin
        bubble     = 1'b1;
        stall_f    = 1'b1;
        count_inc  = 1'b1;
        state_next = STALL;
      end else begin
        capture    = 1'b1;
        state_next = RUN;
      end
    end
  end

  always_comb begin
    ex_valid_next    = ex_valid_reg;
    ex_regwrite_next = ex_regwrite_reg;
    ex_memread_next  = ex_memread_reg;
    ex_rs_next       = ex_rs_reg;
    ex_rd_next       = ex_rd_reg;
    ex_writereg_next = ex_writereg_reg;
    ex_aluop_next    = ex_aluop_reg;
    ex_a_next        = ex_a_reg;
    ex_b_next        = ex_b_reg;
    ex_imm_next      = ex_imm_reg;
    if (bubble) begin
      ex_valid_next    = 1'b0;
      ex_regwrite_next = 1'b0;
      ex_memread_next  = 1'b0;
      ex_rs_next       = '0;
      ex_rd_next       = '0;
      ex_writereg_next = '0;
      ex_aluop_next    = '0;
      ex_a_next        = '0;
      ex_b_next        = '0;
      ex_imm_next      = '0;
    end else if (capture) begin
      // An invalid slot must never carry write or load side effects downstream.
      ex_valid_next    = bus.id_valid;
      ex_regwrite_next = bus.id_valid && bus.id_regwrite;
      ex_memread_next  = bus.id_valid && bus.id_memread;
      ex_rs_next       = bus.id_rs;
      ex_rd_next       = bus.id_rd;
      ex_writereg_next = bus.id_writereg;
      ex_aluop_next    = bus.id_aluop;
      ex_a_next        = opnd[0];
      ex_b_next        = opnd[1];
      ex_imm_next      = bus.id_imm;
    end
  end

  assign stall_count_next = (count_inc && (stall_count_reg != '1)) ?
                            stall_count_reg + CW'(1) : stall_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      ex_valid_reg    <= 1'b0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_rs_reg       <= '0;
      ex_rd_reg       <= '0;
      ex_writereg_reg <= '0;
      ex_aluop_reg    <= '0;
      ex_a_reg        <= '0;
      ex_b_reg        <= '0;
      ex_imm_reg      <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      ex_valid_reg    <= ex_valid_next;
      ex_regwrite_reg <= ex_regwrite_next;
      ex_memread_reg  <= ex_memread_next;
      ex_rs_reg       <= ex_rs_next;
      ex_rd_reg       <= ex_rd_next;
      ex_writereg_reg <= ex_writereg_next;
      ex_aluop_reg    <= ex_aluop_next;
      ex_a_reg        <= ex_a_next;
      ex_b_reg        <= ex_b_next;
      ex_imm_reg      <= ex_imm_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign bus.stall_f     = stall_f;
  assign bus.flush_d     = flush_d;
  assign bus.ex_valid    = ex_valid_reg;
  assign bus.ex_regwrite = ex_regwrite_reg;
  assign bus.ex_memread  = ex_memread_reg;
  assign bus.ex_rs       = ex_rs_reg;
  assign bus.ex_rd       = ex_rd_reg;
  assign bus.ex_writereg = ex_writereg_reg;
  assign bus.ex_aluop    = ex_aluop_reg;
  assign bus.ex_a        = ex_a_reg;
  assign bus.ex_b        = ex_b_reg;
  assign bus.ex_imm      = ex_imm_reg;
  assign bus.stall_count = stall_count_reg;
endmodule
